// File: rtl/hcount_source.sv
// hcount_source: drives a four-phase req/ack channel with numbered messages; ack is debounced.
// Define HCOUNT_SOURCE_REDUN_EN to fill the redundancy field with (DEST_ADDR + data) mod 2^RSZ.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif
`ifndef NS_REQ_CKS
`define NS_REQ_CKS 2
`endif

module hcount_source #(
  parameter int unsigned    ASZ        = `NS_ADDRESS_SIZE,
  parameter int unsigned    DSZ        = `NS_DATA_SIZE,
  parameter int unsigned    RSZ        = `NS_REDUN_SIZE,
  parameter logic [ASZ-1:0] DEST_ADDR  = '0,
  parameter logic [DSZ-1:0] FIRST_DATA = '0,
  parameter logic [15:0]    MAX_MSGS   = 16'd0,
  parameter int unsigned    ACK_CKS    = `NS_REQ_CKS
) (
  input  logic                 gch_clk,
  input  logic                 gch_reset,
  output logic                 gch_ready,
  output logic                 snd0_req,
  input  logic                 snd0_ack,
  output logic [ASZ+DSZ+RSZ-1:0] snd0_data,
  output logic                 done
);

  localparam int unsigned CKS      = (ACK_CKS == 0) ? 1 : ACK_CKS;
  localparam int unsigned CW       = $clog2(CKS + 1);
  localparam logic [CW-1:0] CKS_LAST = CW'(CKS - 1);

  typedef enum logic [1:0] {S_INIT, S_REQ_HI, S_REQ_LO, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [CW-1:0]  samp_q, samp_d;
  logic           ckd_ack_q, ckd_ack_d;
  logic           snd0_rdy;
  logic           req_q, req_d;
  logic           done_q, done_d;
  logic           rg_rdy_q, rg_rdy_d;
  logic [DSZ-1:0] data_q, data_d, data_ld;
  logic [RSZ-1:0] redun_q, redun_d, redun_nx;
  logic [15:0]    count_q, count_d;
  logic           load;

  // Ack debouncer: a new level is accepted after CKS consecutive samples of it.
  always_comb begin
    deb_cnt_d = '0;
    ckd_ack_d = ckd_ack_q;
    samp_d    = samp_q;
    if (samp_q != CKS_LAST) samp_d = samp_q + CW'(1);
    if (snd0_ack != ckd_ack_q) begin
      if (deb_cnt_q == CKS_LAST) ckd_ack_d = snd0_ack;
      else                       deb_cnt_d = deb_cnt_q + CW'(1);
    end
  end

  // The edge taking the CKS-th sample since reset is the first one that may leave INIT.
  assign snd0_rdy = (samp_q == CKS_LAST);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    done_d   = done_q;
    rg_rdy_d = rg_rdy_q;
    count_d  = count_q;
    load     = 1'b0;
    data_ld  = FIRST_DATA;
    case (state_q)
      S_INIT: begin
        if (snd0_rdy) begin
          state_d  = S_REQ_HI;
          req_d    = 1'b1;
          rg_rdy_d = 1'b1;
          count_d  = '0;
          load     = 1'b1;
        end
      end
      S_REQ_HI: begin
        if (ckd_ack_q) begin
          state_d = S_REQ_LO;
          req_d   = 1'b0;
        end
      end
      S_REQ_LO: begin
        if (!ckd_ack_q) begin
          count_d = count_q + 16'd1;
          if ((MAX_MSGS != 16'd0) && (count_d == MAX_MSGS)) begin
            state_d = S_DONE;
            req_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_REQ_HI;
            req_d   = 1'b1;
            load    = 1'b1;
            data_ld = data_q + DSZ'(1);
          end
        end
      end
      S_DONE:  req_d = 1'b0;
      default: state_d = S_INIT;
    endcase
  end

  // Data and redundancy are captured together, only when a new message is launched.
  always_comb begin
`ifdef HCOUNT_SOURCE_REDUN_EN
    redun_nx = RSZ'(DEST_ADDR) + RSZ'(data_ld);
`else
    redun_nx = '0;
`endif
    data_d  = load ? data_ld  : data_q;
    redun_d = load ? redun_nx : redun_q;
  end

  always_ff @(posedge gch_clk) begin
    if (gch_reset) begin
      state_q   <= S_INIT;
      deb_cnt_q <= '0;
      samp_q    <= '0;
      ckd_ack_q <= 1'b0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      rg_rdy_q  <= 1'b0;
      count_q   <= '0;
      data_q    <= '0;
      redun_q   <= '0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
      samp_q    <= samp_d;
      ckd_ack_q <= ckd_ack_d;
      req_q     <= req_d;
      done_q    <= done_d;
      rg_rdy_q  <= rg_rdy_d;
      count_q   <= count_d;
      data_q    <= data_d;
      redun_q   <= redun_d;
    end
  end

  // Address field reads as zero until the first message is loaded.
  assign snd0_data = {(rg_rdy_q ? DEST_ADDR : {ASZ{1'b0}}), data_q, redun_q};
  assign snd0_req  = req_q;
  assign done      = done_q;
  assign gch_ready = rg_rdy_q & snd0_rdy;

endmodule
